// File: rtl/apb_rr_pkg.sv
// Shared types and helpers for the round-robin APB master.
package apb_rr_pkg;

    localparam int unsigned DefNumReq  = 4;
    localparam int unsigned DefAddrW   = 8;
    localparam int unsigned DefDataW   = 8;
    localparam int unsigned DefTimeout = 16;
    localparam int unsigned MaxReq     = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    // Index of the first set bit of vec, searching upward from ptr+1 and wrapping at n.
    function automatic logic [2:0] rr_first(input logic [MaxReq-1:0] vec,
                                            input logic [2:0]        ptr,
                                            input int unsigned       n);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MaxReq; i++) begin
            if (i <= n) begin
                idx = (32'(ptr) + i) % n;
                if (!found && vec[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/apb_rr_master_if.sv
// APB bus bundle between the round-robin master and a slave segment.
interface apb_rr_master_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) ();
    logic              P_sel;
    logic              P_enable;
    logic              P_write;
    logic [ADDR_W-1:0] P_addr;
    logic [DATA_W-1:0] P_wdata;
    logic [DATA_W-1:0] P_rdata;
    logic              P_ready;
    logic              P_slverr;

    modport master (
        output P_sel, P_enable, P_write, P_addr, P_wdata,
        input  P_rdata, P_ready, P_slverr
    );

    modport slave (
        input  P_sel, P_enable, P_write, P_addr, P_wdata,
        output P_rdata, P_ready, P_slverr
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin winner select with a registered last-winner pointer.
module rr_arbiter
    import apb_rr_pkg::*;
#(
    parameter  int unsigned NumReq = DefNumReq,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NumReq-1:0] eligible,
    input  logic              update,
    output logic              any,
    output logic [IdxW-1:0]   winner,
    output logic [NumReq-1:0] winner_oh
);

    logic [IdxW-1:0] ptr_q;

    always_comb begin
        any       = |eligible;
        winner    = IdxW'(rr_first(MaxReq'(eligible), 3'(ptr_q), NumReq));
        winner_oh = '0;
        if (any) winner_oh[winner] = 1'b1;
    end

    // Reset to the last requester so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= IdxW'(NumReq - 1);
        end else if (update && any) begin
            ptr_q <= winner;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// Multi-requester APB master with round-robin arbitration.
// Define APB_RR_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT_CYCLES without P_ready.
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DefNumReq,
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter int unsigned DATA_W         = DefDataW,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeout
) (
    input  logic                      P_clk,
    input  logic                      P_reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    apb_rr_master_if.master           apb
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > MaxReq || TIMEOUT_CYCLES == 0) begin : g_param_check
        $error("apb_rr_master: unsupported parameter set");
    end

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d;
    logic                err_q, err_d, busy_q, busy_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                sel_q, sel_d, en_q, en_d, write_q, write_d;
    logic                any;
    logic [IdxW-1:0]     winner;
    logic [NUM_REQ-1:0]  winner_oh;
    logic                finish;

`ifdef APB_RR_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`endif

    rr_arbiter #(
        .NumReq (NUM_REQ)
    ) u_arb (
        .clk       (P_clk),
        .rst       (P_reset),
        .eligible  (req & ~done_q),
        .update    (state_q == StIdle),
        .any       (any),
        .winner    (winner),
        .winner_oh (winner_oh)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        sel_d   = sel_q;
        en_d    = en_q;
        finish  = 1'b0;
`ifdef APB_RR_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (any) begin
                    write_d = req_rw[winner];
                    addr_d  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[int'(winner)*DATA_W +: DATA_W];
                    gnt_d   = winner_oh;
                    sel_d   = 1'b1;
                    busy_d  = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                en_d    = 1'b1;
                state_d = StAccess;
`ifdef APB_RR_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StAccess: begin
                if (apb.P_ready) begin
                    finish = 1'b1;
                    err_d  = apb.P_slverr;
                    if (!write_q) rdata_d = apb.P_rdata;
`ifdef APB_RR_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    finish  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
        if (finish) begin
            done_d  = gnt_q;
            gnt_d   = '0;
            sel_d   = 1'b0;
            en_d    = 1'b0;
            busy_d  = 1'b0;
            state_d = StIdle;
        end
    end

    always_ff @(posedge P_clk or posedge P_reset) begin
        if (P_reset) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            sel_q   <= 1'b0;
            en_q    <= 1'b0;
`ifdef APB_RR_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
`ifdef APB_RR_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign busy         = busy_q;
    assign apb.P_sel    = sel_q;
    assign apb.P_enable = en_q;
    assign apb.P_write  = write_q;
    assign apb.P_addr   = addr_q;
    assign apb.P_wdata  = wdata_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: APB slave model plus a completion scoreboard.
module tb_apb_rr_master;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req, req_rw, gnt, done;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            err, busy;
    logic [DW-1:0]   rdata;

    always #5 clk = ~clk;

    apb_rr_master_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    apb_rr_master #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .P_clk     (clk),
        .P_reset   (rst),
        .req       (req),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .apb       (apb)
    );

    typedef struct {
        logic [N-1:0]  oh;
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          err;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb[$];
    int            n_vec     = 0;
    int            n_fail    = 0;
    int            wait_cfg  = 0;
    int            wait_left = 0;
    logic [DW-1:0] hold      = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Slave answers reads with addr ^ 0x1C and flags an error on writes to 0xFF.
    function automatic void push(input int idx, input logic rw, input logic [AW-1:0] a,
                                 input logic [DW-1:0] wd);
        exp_t e;
        e.oh      = '0;
        e.oh[idx] = 1'b1;
        e.rw      = rw;
        e.addr    = a;
        e.wdata   = wd;
        e.err     = rw && (a == 8'hFF);
        if (!rw) hold = a ^ 8'h1C;
        e.rdata   = hold;
        sb.push_back(e);
    endfunction

    task automatic drive(input int idx, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd);
        req_rw[idx]              = rw;
        req_addr[idx*AW +: AW]   = a;
        req_wdata[idx*DW +: DW]  = wd;
        req[idx]                 = 1'b1;
        push(idx, rw, a, wd);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (apb.P_sel && !apb.P_enable) begin
            wait_left    = wait_cfg;
            apb.P_ready  = 1'b0;
            apb.P_slverr = 1'b0;
        end else if (apb.P_sel && apb.P_enable) begin
            if (wait_left > 0) begin
                wait_left--;
                apb.P_ready = 1'b0;
            end else begin
                apb.P_ready  = 1'b1;
                apb.P_rdata  = apb.P_addr ^ 8'h1C;
                apb.P_slverr = apb.P_write && (apb.P_addr == 8'hFF);
            end
        end else begin
            apb.P_ready  = 1'b0;
            apb.P_slverr = 1'b0;
        end
        if (apb.P_sel && apb.P_enable && sb.size() != 0) begin
            check("acc_addr", 32'(apb.P_addr), 32'(sb[0].addr));
            check("acc_write", 32'(apb.P_write), 32'(sb[0].rw));
            check("acc_gnt", 32'(gnt), 32'(sb[0].oh));
            if (sb[0].rw) check("acc_wdata", 32'(apb.P_wdata), 32'(sb[0].wdata));
        end
        if (done !== '0) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 32'(done), 32'(0));
            end else begin
                e = sb.pop_front();
                check("done_oh", 32'(done), 32'(e.oh));
                check("done_err", 32'(err), 32'(e.err));
                check("done_rdata", 32'(rdata), 32'(e.rdata));
                check("done_idle", 32'({gnt, apb.P_sel, apb.P_enable, busy}), 32'(0));
            end
            req = req & ~done;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((sb.size() != 0 || req != '0) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_fail++;
            $error("FAIL wait_idle: observed %0d pending after %0d cycles, expected 0",
                   sb.size(), n);
            sb.delete();
            req = '0;
        end
    endtask

    task automatic xfer(input int idx, input logic rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int waits, input int exp_lat);
        int lat;
        wait_cfg = waits;
        drive(idx, rw, a, wd);
        tick();
        lat = 1;
        check("setup_phase", 32'({apb.P_sel, apb.P_enable, busy}), 32'(3'b101));
        while (done[idx] !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ctl"}, 32'({gnt, done, err, busy, apb.P_sel, apb.P_enable, apb.P_write}),
              32'(0));
        check({tag, "_data"}, {rdata, apb.P_addr, apb.P_wdata}, 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req          = '0;
        req_rw       = '0;
        req_addr     = '0;
        req_wdata    = '0;
        apb.P_ready  = 1'b0;
        apb.P_rdata  = '0;
        apb.P_slverr = 1'b0;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // All four at once, twice: strict order 0,1,2,3 each round.
        wait_cfg = 0;
        drive(0, 1'b1, 8'h20, 8'h50);
        drive(1, 1'b0, 8'h21, 8'h51);
        drive(2, 1'b1, 8'h22, 8'h52);
        drive(3, 1'b0, 8'h23, 8'h53);
        wait_idle(60);
        drive(0, 1'b0, 8'h60, 8'h00);
        drive(1, 1'b1, 8'h61, 8'h71);
        drive(2, 1'b0, 8'h62, 8'h00);
        drive(3, 1'b1, 8'h63, 8'h73);
        wait_idle(60);

        xfer(0, 1'b1, 8'h12, 8'hA5, 0, 3);
        xfer(2, 1'b0, 8'h40, 8'h00, 2, 5);
        tick();
        check("rdata_hold", 32'(rdata), 32'(8'h5C));

        // Pointer at 1: requester 3 precedes requester 0.
        xfer(1, 1'b1, 8'h30, 8'h11, 0, 3);
        drive(3, 1'b0, 8'h33, 8'h00);
        drive(0, 1'b1, 8'h34, 8'h22);
        wait_idle(40);

        xfer(1, 1'b1, 8'hFF, 8'hEE, 0, 3);
        xfer(2, 1'b1, 8'h33, 8'h44, 1, 4);

        // Reset in the middle of an ACCESS phase.
        wait_cfg = 10;
        drive(0, 1'b0, 8'h77, 8'h00);
        n = 0;
        while (apb.P_enable !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("reach_access", 32'(apb.P_enable), 32'(1));
        #2 rst = 1'b1;
        #1 check_reset("async_reset");
        sb.delete();
        hold = '0;
        req  = '0;
        tick();
        tick();
        rst = 1'b0;
        check("no_done_after_reset", 32'(done), 32'(0));
        wait_cfg = 0;
        drive(0, 1'b1, 8'h01, 8'h91);
        drive(2, 1'b1, 8'h02, 8'h92);
        wait_idle(40);

`ifdef APB_RR_TIMEOUT_EN
        wait_cfg = 40;
        drive(1, 1'b0, 8'h55, 8'h00);
        sb[sb.size()-1].err   = 1'b1;
        sb[sb.size()-1].rdata = '0;
        hold = '0;
        n = 0;
        while (done[1] !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("timeout_latency", 32'(n), 32'(18));
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Multi-requester APB master: accepts up to NUM_REQ independent transfer requests and arbitrates them round-robin.
- Sequences the granted request through APB SETUP/ACCESS phases directly on the P_* bus and returns read data and status to the winner.
- Sits where the single-requester master sits today, letting several on-chip clients share one APB slave segment.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, APB address width
- DATA_W, 8, APB data width
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with APB_RR_TIMEOUT_EN

Ports:
- P_clk  in  1  clock, rising edge
- P_reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester transfer request, level, held until done
- req_rw  in  NUM_REQ  per-requester direction, 1 = write
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at slice i
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- gnt  out  NUM_REQ  one-hot, high from SETUP through the completing ACCESS cycle
- done  out  NUM_REQ  one-hot, one-cycle completion pulse
- err  out  1  slave error for the transfer flagged by done; valid only with done
- rdata  out  DATA_W  read data; valid with done on reads, holds otherwise
- busy  out  1  high in SETUP/ACCESS
- P_sel  out  1  APB select
- P_enable  out  1  APB enable
- P_write  out  1  APB direction
- P_addr  out  ADDR_W  APB address
- P_wdata  out  DATA_W  APB write data
- P_rdata  in  DATA_W  APB read data
- P_ready  in  1  APB ready
- P_slverr  in  1  APB slave error

Behaviour:
- All outputs are registered. On reset, every output is 0, the FSM is in IDLE, and the RR pointer = NUM_REQ-1, so requester 0 has first priority. Reset mid-transfer drops P_sel/P_enable immediately; no done is issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: eligible = req & ~done. If eligible != 0, pick the first set bit searching from pointer+1 upward with wrap. Latch that requester's rw/addr/wdata into P_write/P_addr/P_wdata, set gnt, update pointer to the winner, go to SETUP. Otherwise stay in IDLE.
- SETUP (one cycle): P_sel=1, P_enable=0. Next state is ACCESS.
- ACCESS: P_sel=1, P_enable=1. P_addr/P_write/P_wdata are stable.
  - P_ready=0: stay in ACCESS.
  - P_ready=1: capture P_rdata (reads only) and P_slverr. Go to IDLE. Next cycle: done[winner]=1, err=P_slverr, gnt=0, P_sel=0, P_enable=0.
- Latency with zero-wait slave: request seen in IDLE at cycle T; SETUP T+1; ACCESS T+2; done at T+3. Each P_ready=0 cycle adds one.
- Back-to-back throughput: one transfer per 3 cycles minimum, because IDLE is always visited.
- Requester contract: hold req and operands stable until done, then deassert req in the done cycle. The arbiter masks a requester whose done is high, so a lingering req in that cycle is not re-granted.
- A req dropped before grant is ignored. A req dropped after grant does not abort the transfer; it completes and done still pulses.
- Simultaneous requests are resolved strictly round-robin: no requester waits more than NUM_REQ-1 transfers.
- P_addr/P_wdata/P_write hold their last values in IDLE. rdata holds until the next read completion.

Optional Feature:
- Macro: APB_RR_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with P_ready=0. When it reaches TIMEOUT_CYCLES, the transfer aborts: FSM goes to IDLE, P_sel/P_enable drop, and next cycle done[winner]=1, err=1, rdata=0.
- Undefined: no counter is built; ACCESS waits indefinitely for P_ready.

Decomposition:
- Package apb_rr_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS)
  - default width constants
  - a function returning the first set bit of a rotated vector
- Sub-module rr_arbiter: combinational winner select from eligible+pointer, plus a registered pointer with update enable. All other logic stays in apb_rr_master.

Test Plan:
- Single write, req[0] with addr=0x12, wdata=0xA5, zero-wait slave -> SETUP at T+1, ACCESS at T+2 with P_addr=0x12, P_wdata=0xA5, P_write=1; done[0] at T+3, err=0.
- Read with 2 wait states, req[2] addr=0x40, slave returns 0x5C -> ACCESS lasts 3 cycles; done[2] at T+5 with rdata=0x5C.
- All four req asserted after reset, each held until its done -> grant order 0,1,2,3. Re-assert all four -> order 0,1,2,3 again; no starvation.
- Pointer at 1, req[0] and req[3] held -> req[3] is granted first, then req[0].
- Slave P_slverr=1 on write to 0xFF -> done with err=1. Next transfer completes with err=0.
- P_reset pulsed during ACCESS -> all outputs 0 asynchronously; no done; pointer returns to NUM_REQ-1. With APB_RR_TIMEOUT_EN, a slave holding P_ready=0 for 16 cycles -> done with err=1, rdata=0.
